// File: rtl/mips_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// the hard-wired zero register index and the arbiter state encoding.
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      FORCE = 2'd2
   } rfarb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_starve_timer.sv
// starve_timer: counts how long a held MDU result has waited without being
// written and flags when the wait reaches LIMIT-1. The counter saturates there.
// Only present when RFARB_STARVE_GUARD_EN is defined.
`ifdef RFARB_STARVE_GUARD_EN
module starve_timer #(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic count_en,
   input  logic clear,
   output logic at_limit
);

   localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] wait_cnt_q;
   logic [CNT_W-1:0] wait_cnt_d;

   // Next count: clear wins, otherwise step up until saturated at the limit.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (clear) begin
         wait_cnt_d = '0;
      end else if (count_en && (wait_cnt_q != MAX_CNT)) begin
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
   end

   // Wait counter register, emptied by the active-low asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign at_limit = (wait_cnt_q == MAX_CNT);

endmodule
`endif

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single register-file write port between
// the writeback stage (absolute priority, never back-pressured) and the
// multi-cycle mul/div unit, whose results wait in a one-entry holding register
// until the first cycle WB does not write.
// Optional feature macro: RFARB_STARVE_GUARD_EN adds a starvation timer that
// raises wb_stall once a held result has waited too long.
module regfile_write_arbiter
   import mips_pkg::*;
#(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W
`ifdef RFARB_STARVE_GUARD_EN
   ,
   parameter int STARVE_LIMIT = 4
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_wa,
   input  logic [DATA_W-1:0] wb_wd,
   input  logic              mdu_valid,
   input  logic [ADDR_W-1:0] mdu_wa,
   input  logic [DATA_W-1:0] mdu_wd,
   output logic              mdu_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wa,
   output logic [DATA_W-1:0] rf_wd,
   output logic              mdu_pend,
   output logic [ADDR_W-1:0] mdu_pend_wa,
   output logic              wb_stall
);

   localparam logic [ADDR_W-1:0] ZERO_WA = ADDR_W'(REG_ZERO);

   rfarb_state_t      state_q;
   rfarb_state_t      state_d;
   logic [ADDR_W-1:0] pend_wa_q;
   logic [ADDR_W-1:0] pend_wa_d;
   logic [DATA_W-1:0] pend_wd_q;
   logic [DATA_W-1:0] pend_wd_d;

   logic pend;
   logic wb_grant;
   logic drain;
   logic discard;
   logic load;
   logic load_keep;

   // Grant decode: WB owns the port whenever it writes a real register; the
   // held entry drains otherwise, and a WB write to the held address kills it.
   always_comb begin
      pend      = (state_q != IDLE);
      wb_grant  = wb_we && (wb_wa != ZERO_WA);
      drain     = pend && !wb_grant;
      discard   = pend && wb_grant && (wb_wa == pend_wa_q);
      mdu_ready = !pend || drain;
      load      = mdu_valid && mdu_ready;
      load_keep = load && (mdu_wa != ZERO_WA);
   end

   // Register-file port drive; forced quiet while reset is asserted.
   always_comb begin
      rf_we = 1'b0;
      rf_wa = '0;
      rf_wd = '0;
      if (rst) begin
         if (wb_grant) begin
            rf_we = 1'b1;
            rf_wa = wb_wa;
            rf_wd = wb_wd;
         end else if (pend) begin
            rf_we = 1'b1;
            rf_wa = pend_wa_q;
            rf_wd = pend_wd_q;
         end
      end
   end

   // Hazard-unit view of the holding register.
   always_comb begin
      mdu_pend    = pend;
      mdu_pend_wa = pend ? pend_wa_q : '0;
   end

   // Holding-register payload: captured only for results aimed at a real register.
   always_comb begin
      pend_wa_d = pend_wa_q;
      pend_wd_d = pend_wd_q;
      if (load_keep) begin
         pend_wa_d = mdu_wa;
         pend_wd_d = mdu_wd;
      end
   end

`ifdef RFARB_STARVE_GUARD_EN
   logic at_limit;
   logic timer_count;
   logic timer_clear;

   // Timer control: count waiting HOLD cycles, restart whenever the entry leaves.
   always_comb begin
      timer_count = (state_q == HOLD) && !drain && !discard;
      timer_clear = !pend || drain || discard;
   end

   starve_timer #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_timer (
      .clk      (clk),
      .rst      (rst),
      .count_en (timer_count),
      .clear    (timer_clear),
      .at_limit (at_limit)
   );

   assign wb_stall = (state_q == FORCE);
`else
   assign wb_stall = 1'b0;
`endif

   // Next-state logic: the state doubles as the holding register's valid bit.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (load_keep) begin
               state_d = HOLD;
            end
         end
         HOLD, FORCE: begin
            if (drain || discard) begin
               state_d = load_keep ? HOLD : IDLE;
            end
`ifdef RFARB_STARVE_GUARD_EN
            else if ((state_q == HOLD) && at_limit) begin
               state_d = FORCE;
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and payload registers; reset drops any held result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pend_wa_q <= '0;
         pend_wd_q <= '0;
      end else begin
         state_q   <= state_d;
         pend_wa_q <= pend_wa_d;
         pend_wd_q <= pend_wd_d;
      end
   end

   // Register 0 must never be written through the port.
   a_no_zero_write : assert property (@(posedge clk) disable iff (!rst)
      rf_we |-> (rf_wa != ZERO_WA));

   // A held entry never points at register 0.
   a_no_zero_hold : assert property (@(posedge clk) disable iff (!rst)
      pend |-> (pend_wa_q != ZERO_WA));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed vector table, hand-written
// reset and starvation sequences, then randomized traffic against a
// transaction-level model of the write port.
module tb_regfile_write_arbiter;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int LIMIT = 4;
`ifdef RFARB_STARVE_GUARD_EN
   localparam bit GUARD      = 1'b1;
   localparam int STARVE_CYC = 4;
`else
   localparam bit GUARD      = 1'b0;
   localparam int STARVE_CYC = 100;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_we;
   logic [AW-1:0] wb_wa;
   logic [DW-1:0] wb_wd;
   logic          mdu_valid;
   logic [AW-1:0] mdu_wa;
   logic [DW-1:0] mdu_wd;
   logic          mdu_ready;
   logic          rf_we;
   logic [AW-1:0] rf_wa;
   logic [DW-1:0] rf_wd;
   logic          mdu_pend;
   logic [AW-1:0] mdu_pend_wa;
   logic          wb_stall;

   int tests = 0;
   int fails = 0;

   // Model: the held result (if any) and how many cycles it has waited unwritten.
   bit            m_h;
   logic [AW-1:0] m_wa;
   logic [DW-1:0] m_wd;
   int            m_wait;

   typedef struct {
      logic          wb_we;
      logic [AW-1:0] wb_wa;
      logic [DW-1:0] wb_wd;
      logic          mdu_valid;
      logic [AW-1:0] mdu_wa;
      logic [DW-1:0] mdu_wd;
      logic          exp_we;
      logic [AW-1:0] exp_wa;
      logic [DW-1:0] exp_wd;
      logic          exp_ready;
      logic          exp_pend;
      logic [AW-1:0] exp_pend_wa;
   } vec_t;

   vec_t vecs[15];

   always #5 clk = ~clk;

   regfile_write_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .wb_we       (wb_we),
      .wb_wa       (wb_wa),
      .wb_wd       (wb_wd),
      .mdu_valid   (mdu_valid),
      .mdu_wa      (mdu_wa),
      .mdu_wd      (mdu_wd),
      .mdu_ready   (mdu_ready),
      .rf_we       (rf_we),
      .rf_wa       (rf_wa),
      .rf_wd       (rf_wd),
      .mdu_pend    (mdu_pend),
      .mdu_pend_wa (mdu_pend_wa),
      .wb_stall    (wb_stall)
   );

   task automatic check1(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic v, input logic [AW-1:0] mwa, input logic [DW-1:0] mwd);
      @(negedge clk);
      wb_we     = we;
      wb_wa     = wa;
      wb_wd     = wd;
      mdu_valid = v;
      mdu_wa    = mwa;
      mdu_wd    = mwd;
      #2;
   endtask

   // Compare every output with what the model predicts for the current inputs.
   task automatic checkOutput(input string tag);
      logic          wbg;
      logic          e_we;
      logic [AW-1:0] e_wa;
      logic [DW-1:0] e_wd;
      wbg  = wb_we && (wb_wa != 0);
      e_we = wbg || m_h;
      e_wa = wbg ? wb_wa : (m_h ? m_wa : '0);
      e_wd = wbg ? wb_wd : (m_h ? m_wd : '0);
      check1({tag, " rf_we"}, DW'(rf_we), DW'(e_we));
      check1({tag, " rf_wa"}, DW'(rf_wa), DW'(e_wa));
      check1({tag, " rf_wd"}, rf_wd, e_wd);
      check1({tag, " mdu_ready"}, DW'(mdu_ready), DW'(!m_h || !wbg));
      check1({tag, " mdu_pend"}, DW'(mdu_pend), DW'(m_h));
      check1({tag, " mdu_pend_wa"}, DW'(mdu_pend_wa), DW'(m_h ? m_wa : '0));
      check1({tag, " wb_stall"}, DW'(wb_stall), DW'(GUARD && m_h && (m_wait >= LIMIT)));
   endtask

   // Advance the model across the next rising edge using the applied inputs.
   task automatic stepModel();
      logic wbg;
      logic drain;
      logic discard;
      logic load;
      @(posedge clk);
      wbg     = wb_we && (wb_wa != 0);
      drain   = m_h && !wbg;
      discard = m_h && wbg && (wb_wa == m_wa);
      load    = mdu_valid && (!m_h || drain) && (mdu_wa != 0);
      if (load) begin
         m_h    = 1'b1;
         m_wa   = mdu_wa;
         m_wd   = mdu_wd;
         m_wait = 0;
      end else if (drain || discard) begin
         m_h    = 1'b0;
         m_wait = 0;
      end else if (m_h) begin
         m_wait++;
      end
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst       = 1'b0;
      wb_we     = 1'b0;
      wb_wa     = '0;
      wb_wd     = '0;
      mdu_valid = 1'b0;
      mdu_wa    = '0;
      mdu_wd    = '0;
      m_h       = 1'b0;
      m_wa      = '0;
      m_wd      = '0;
      m_wait    = 0;
      repeat (2) @(posedge clk);
      #1;
      check1("reset rf_we", DW'(rf_we), 0);
      check1("reset mdu_pend", DW'(mdu_pend), 0);
      check1("reset mdu_ready", DW'(mdu_ready), 1);
      check1("reset wb_stall", DW'(wb_stall), 0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b1, 5'd3,  32'hAAAA0001, 1'b1, 5'd5,  32'h12345678, 1'b1, 5'd3,  32'hAAAA0001, 1'b1, 1'b0, 5'd0};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'h12345678, 1'b1, 1'b1, 5'd5};
      vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'hDEAD0007, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0};
      vecs[3]  = '{1'b1, 5'd7,  32'h1,        1'b1, 5'd8,  32'hBBBB0008, 1'b1, 5'd7,  32'h1,        1'b0, 1'b1, 5'd7};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0};
      vecs[5]  = '{1'b1, 5'd0,  32'h55,       1'b1, 5'd0,  32'h66,       1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0};
      vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'hA,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0};
      vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 32'hB,        1'b1, 5'd10, 32'hA,        1'b1, 1'b1, 5'd10};
      vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 32'hB,        1'b1, 1'b1, 5'd11};
      vecs[10] = '{1'b1, 5'd3,  32'hC,        1'b1, 5'd5,  32'hD,        1'b1, 5'd3,  32'hC,        1'b1, 1'b0, 5'd0};
      vecs[11] = '{1'b1, 5'd4,  32'hE,        1'b1, 5'd6,  32'hF,        1'b1, 5'd4,  32'hE,        1'b0, 1'b1, 5'd5};
      vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'hD,        1'b1, 1'b1, 5'd5};
      vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h12,       1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0};
      vecs[14] = '{1'b1, 5'd0,  32'h99,       1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h12,       1'b1, 1'b1, 5'd12};

      doReset();

      // Directed vectors: priority, back-to-back drain, WAW discard, register 0.
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].wb_we, vecs[i].wb_wa, vecs[i].wb_wd,
                       vecs[i].mdu_valid, vecs[i].mdu_wa, vecs[i].mdu_wd);
         check1($sformatf("vec%0d rf_we", i), DW'(rf_we), DW'(vecs[i].exp_we));
         check1($sformatf("vec%0d rf_wa", i), DW'(rf_wa), DW'(vecs[i].exp_wa));
         check1($sformatf("vec%0d rf_wd", i), rf_wd, vecs[i].exp_wd);
         check1($sformatf("vec%0d mdu_ready", i), DW'(mdu_ready), DW'(vecs[i].exp_ready));
         check1($sformatf("vec%0d mdu_pend", i), DW'(mdu_pend), DW'(vecs[i].exp_pend));
         check1($sformatf("vec%0d mdu_pend_wa", i), DW'(mdu_pend_wa), DW'(vecs[i].exp_pend_wa));
         check1($sformatf("vec%0d wb_stall", i), DW'(wb_stall), 0);
         stepModel();
      end

      // Asynchronous reset in the middle of traffic with a result held.
      doReset();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9999);
      checkOutput("rstseq load");
      stepModel();
      applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
      checkOutput("rstseq wb");
      #1;
      rst = 1'b0;
      #1;
      check1("midreset rf_we", DW'(rf_we), 0);
      check1("midreset rf_wa", DW'(rf_wa), 0);
      check1("midreset mdu_pend", DW'(mdu_pend), 0);
      check1("midreset mdu_ready", DW'(mdu_ready), 1);
      check1("midreset wb_stall", DW'(wb_stall), 0);
      @(negedge clk);
      rst    = 1'b1;
      m_h    = 1'b0;
      m_wait = 0;
      wb_we  = 1'b0;
      mdu_valid = 1'b0;

      // Starvation: hold r9 while WB writes every cycle, then go idle.
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9999);
      checkOutput("starve load");
      stepModel();
      for (int i = 0; i < STARVE_CYC; i++) begin
         applyStimulus(1'b1, AW'(1 + (i % 6)), DW'(i), 1'b0, 5'd0, 32'h0);
         checkOutput("starve wb");
         stepModel();
      end
      applyStimulus(1'b1, 5'd2, 32'h2222, 1'b0, 5'd0, 32'h0);
      check1("starve stall level", DW'(wb_stall), DW'(GUARD));
      check1("starve still pend", DW'(mdu_pend), 1);
      stepModel();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check1("starve drain we", DW'(rf_we), 1);
      check1("starve drain wa", DW'(rf_wa), 9);
      check1("starve drain wd", rf_wd, 32'h9999);
      stepModel();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check1("starve after stall", DW'(wb_stall), 0);
      check1("starve after pend", DW'(mdu_pend), 0);
      stepModel();

      // Randomized traffic with a small address range to provoke collisions.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom % 10) < 6, AW'($urandom % 8), $urandom,
                       ($urandom % 2) == 1, AW'($urandom % 8), $urandom);
         checkOutput("rand");
         stepModel();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
